// File: rtl/pe_ws_pkg.sv
// Shared widths, operand types and the extended-product helper for the weight-stationary PE.
package pe_ws_pkg;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 24;

    typedef logic [WIDTH-1:0]     operand_t;
    typedef logic [ACC_WIDTH-1:0] acc_t;

    // Operands are widened to the accumulator width first so the product is exact mod 2^ACC_WIDTH
    function automatic acc_t ext_product(operand_t w, operand_t a, logic signed_mode);
        acc_t w_ext;
        acc_t a_ext;
        w_ext = {{(ACC_WIDTH-WIDTH){signed_mode & w[WIDTH-1]}}, w};
        a_ext = {{(ACC_WIDTH-WIDTH){signed_mode & a[WIDTH-1]}}, a};
        return w_ext * a_ext;
    endfunction

endpackage

// File: rtl/pe_csa3.sv
// Combinational 3:2 carry-save compressor; the carry vector is returned already shifted left by one.
module pe_csa3 #(
    parameter int ACC_WIDTH = pe_ws_pkg::ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] x,
    input  logic [ACC_WIDTH-1:0] y,
    input  logic [ACC_WIDTH-1:0] z,
    output logic [ACC_WIDTH-1:0] sum,
    output logic [ACC_WIDTH-1:0] carry
);

    logic [ACC_WIDTH-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    // The top majority bit falls off: all arithmetic is modulo 2^ACC_WIDTH
    assign carry = {maj[ACC_WIDTH-2:0], 1'b0};

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with double-buffered weights, shift chain, swap token and stall.
// Define PE_WS_DBUF_RESOLVE_EN to replace the carry-save output with a carry-propagate adder.
module pe_ws_dbuf #(
    parameter int WIDTH     = pe_ws_pkg::WIDTH,
    parameter int ACC_WIDTH = pe_ws_pkg::ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 signed_mode,
    input  logic                 w_shift,
    input  logic [WIDTH-1:0]     w_in,
    output logic [WIDTH-1:0]     w_out,
    output logic                 w_shift_out,
    input  logic                 swap_in,
    output logic                 swap_out,
    input  logic [WIDTH-1:0]     a_in,
    input  logic                 a_valid_in,
    output logic [WIDTH-1:0]     a_out,
    output logic                 a_valid_out,
    input  logic [ACC_WIDTH-1:0] ps_sum_in,
    input  logic [ACC_WIDTH-1:0] ps_carry_in,
    output logic [ACC_WIDTH-1:0] ps_sum_out,
    output logic [ACC_WIDTH-1:0] ps_carry_out
);

    logic [WIDTH-1:0]     w_shadow;
    logic [WIDTH-1:0]     w_active;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0] next_sum;
    logic [ACC_WIDTH-1:0] next_carry;

    // Sign- or zero-extend to the accumulator width; an invalid activation contributes nothing
    assign w_ext   = {{(ACC_WIDTH-WIDTH){signed_mode & w_active[WIDTH-1]}}, w_active};
    assign a_ext   = {{(ACC_WIDTH-WIDTH){signed_mode & a_in[WIDTH-1]}}, a_in};
    assign product = a_valid_in ? (w_ext * a_ext) : '0;

`ifdef PE_WS_DBUF_RESOLVE_EN
    assign next_sum   = ps_sum_in + ps_carry_in + product;
    assign next_carry = '0;
`else
    pe_csa3 #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_csa (
        .x     (ps_sum_in),
        .y     (ps_carry_in),
        .z     (product),
        .sum   (next_sum),
        .carry (next_carry)
    );
`endif

    // Swap reads the pre-shift shadow, so a simultaneous shift and swap promotes the old shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            w_shadow     <= '0;
            w_active     <= '0;
            w_out        <= '0;
            w_shift_out  <= 1'b0;
            swap_out     <= 1'b0;
            a_out        <= '0;
            a_valid_out  <= 1'b0;
            ps_sum_out   <= '0;
            ps_carry_out <= '0;
        end else if (en) begin
            if (w_shift) begin
                w_shadow <= w_in;
                w_out    <= w_shadow;
            end
            if (swap_in) begin
                w_active <= w_shadow;
            end
            w_shift_out  <= w_shift;
            swap_out     <= swap_in;
            a_out        <= a_in;
            a_valid_out  <= a_valid_in;
            ps_sum_out   <= next_sum;
            ps_carry_out <= next_carry;
        end
    end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Directed and randomised self-checking bench for pe_ws_dbuf (works with or without PE_WS_DBUF_RESOLVE_EN).
module tb_pe_ws_dbuf;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        signed_mode;
    logic        w_shift;
    logic [7:0]  w_in;
    logic [7:0]  w_out;
    logic        w_shift_out;
    logic        swap_in;
    logic        swap_out;
    logic [7:0]  a_in;
    logic        a_valid_in;
    logic [7:0]  a_out;
    logic        a_valid_out;
    logic [23:0] ps_sum_in;
    logic [23:0] ps_carry_in;
    logic [23:0] ps_sum_out;
    logic [23:0] ps_carry_out;

    int errors = 0;
    int checks = 0;

    pe_ws_dbuf #(.WIDTH(8), .ACC_WIDTH(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .signed_mode  (signed_mode),
        .w_shift      (w_shift),
        .w_in         (w_in),
        .w_out        (w_out),
        .w_shift_out  (w_shift_out),
        .swap_in      (swap_in),
        .swap_out     (swap_out),
        .a_in         (a_in),
        .a_valid_in   (a_valid_in),
        .a_out        (a_out),
        .a_valid_out  (a_valid_out),
        .ps_sum_in    (ps_sum_in),
        .ps_carry_in  (ps_carry_in),
        .ps_sum_out   (ps_sum_out),
        .ps_carry_out (ps_carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] resolved();
        return ps_sum_out + ps_carry_out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en          = 1'b1;
        w_shift     = 1'b0;
        swap_in     = 1'b0;
        w_in        = 8'd0;
        a_in        = 8'd0;
        a_valid_in  = 1'b0;
        ps_sum_in   = 24'd0;
        ps_carry_in = 24'd0;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        en          = 1'b1;
        signed_mode = 1'b1;
        w_shift     = 1'b1;
        swap_in     = 1'b1;
        w_in        = 8'h55;
        a_in        = 8'h3C;
        a_valid_in  = 1'b1;
        ps_sum_in   = 24'h012345;
        ps_carry_in = 24'h000F00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({w_out, w_shift_out, swap_out, a_out, a_valid_out} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got w_out=%h shift=%b swap=%b a_out=%h av=%b, expected all 0",
                     w_out, w_shift_out, swap_out, a_out, a_valid_out);
        end
        checks++;
        if ({ps_sum_out, ps_carry_out} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset_ps: got sum=%h carry=%h, expected 0/0", ps_sum_out, ps_carry_out);
        end
        rst = 1'b0;
        idle_inputs();
        a_in       = 8'd5;
        a_valid_in = 1'b1;
        tick();
        checks++;
        if (resolved() !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_weight_zero: got %0d, expected 0", resolved());
        end
        checks++;
        if (a_out !== 8'd5 || a_valid_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL act_pass: got a_out=%0d av=%b, expected 5/1", a_out, a_valid_out);
        end
    endtask

    task automatic test_chain_load();
        idle_inputs();
        w_shift = 1'b1;
        w_in    = 8'd3;
        tick();
        w_in = 8'd7;
        tick();
        checks++;
        if (w_out !== 8'd3 || w_shift_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chain_w_out: got w_out=%0d shift_out=%b, expected 3/1", w_out, w_shift_out);
        end
        w_shift = 1'b0;
        swap_in = 1'b1;
        tick();
        checks++;
        if (swap_out !== 1'b1 || w_shift_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_token: got swap_out=%b shift_out=%b, expected 1/0", swap_out, w_shift_out);
        end
        swap_in     = 1'b0;
        signed_mode = 1'b1;
        a_in        = 8'd4;
        a_valid_in  = 1'b1;
        tick();
        checks++;
        if (resolved() !== 24'd28) begin
            errors++;
            $display("[TB] FAIL chain_mac: got %0d, expected 28", resolved());
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        w_shift = 1'b1;
        w_in    = 8'd2;
        tick();
        w_shift = 1'b0;
        swap_in = 1'b1;
        tick();
        swap_in = 1'b0;
        w_shift = 1'b1;
        w_in    = 8'd9;
        tick();
        swap_in    = 1'b1;
        w_in       = 8'd6;
        a_in       = 8'd3;
        a_valid_in = 1'b1;
        tick();
        checks++;
        if (resolved() !== 24'd6) begin
            errors++;
            $display("[TB] FAIL swap_cycle_mac: got %0d, expected 6", resolved());
        end
        checks++;
        if (w_out !== 8'd9) begin
            errors++;
            $display("[TB] FAIL swap_shift_w_out: got %0d, expected 9", w_out);
        end
        w_shift = 1'b0;
        swap_in = 1'b0;
        tick();
        checks++;
        if (resolved() !== 24'd27) begin
            errors++;
            $display("[TB] FAIL new_active_mac: got %0d, expected 27", resolved());
        end
        w_shift    = 1'b1;
        w_in       = 8'd0;
        a_valid_in = 1'b0;
        tick();
        checks++;
        if (w_out !== 8'd6) begin
            errors++;
            $display("[TB] FAIL shadow_after_swap: got %0d, expected 6", w_out);
        end
    endtask

    task automatic test_signed_unsigned();
        idle_inputs();
        w_shift = 1'b1;
        w_in    = 8'hFF;
        tick();
        w_shift = 1'b0;
        swap_in = 1'b1;
        tick();
        swap_in     = 1'b0;
        a_in        = 8'h02;
        a_valid_in  = 1'b1;
        ps_sum_in   = 24'd100;
        signed_mode = 1'b1;
        tick();
        checks++;
        if (resolved() !== 24'd98) begin
            errors++;
            $display("[TB] FAIL signed_mac: got %0d, expected 98", resolved());
        end
        signed_mode = 1'b0;
        tick();
        checks++;
        if (resolved() !== 24'd610) begin
            errors++;
            $display("[TB] FAIL unsigned_mac: got %0d, expected 610", resolved());
        end
        signed_mode = 1'b1;
    endtask

    task automatic test_stall();
        idle_inputs();
        swap_in    = 1'b1;
        w_shift    = 1'b1;
        w_in       = 8'h11;
        a_in       = 8'd3;
        a_valid_in = 1'b1;
        ps_sum_in  = 24'd10;
        tick();
        en          = 1'b0;
        swap_in     = 1'b0;
        w_shift     = 1'b0;
        w_in        = 8'h22;
        a_in        = 8'd9;
        a_valid_in  = 1'b0;
        ps_sum_in   = 24'd500;
        ps_carry_in = 24'd44;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (swap_out !== 1'b1 || w_shift_out !== 1'b1 || a_out !== 8'd3 || a_valid_out !== 1'b1 ||
                w_out !== 8'hFF || resolved() !== 24'd7) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got swap=%b shift=%b a=%0d av=%b w_out=%h ps=%0d, expected 1 1 3 1 ff 7",
                         i, swap_out, w_shift_out, a_out, a_valid_out, w_out, resolved());
            end
        end
        en          = 1'b1;
        a_valid_in  = 1'b0;
        ps_sum_in   = 24'hFFFFFF;
        ps_carry_in = 24'd1;
        tick();
        checks++;
        if (resolved() !== 24'd0 || a_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_wrap: got ps=%0d av=%b, expected 0/0", resolved(), a_valid_out);
        end
        a_in       = 8'd1;
        a_valid_in = 1'b1;
        ps_sum_in  = 24'd0;
        ps_carry_in = 24'd0;
        tick();
        checks++;
        if (resolved() !== 24'hFFFFFF) begin
            errors++;
            $display("[TB] FAIL weight_held_through_stall: got %h, expected ffffff", resolved());
        end
    endtask

    task automatic test_random();
        logic [7:0]  w;
        logic [31:0] wv;
        logic [31:0] av;
        logic [23:0] expected;
        for (int k = 0; k < 100; k++) begin
            idle_inputs();
            w       = 8'($urandom_range(0, 255));
            w_shift = 1'b1;
            w_in    = w;
            tick();
            w_shift = 1'b0;
            swap_in = 1'b1;
            tick();
            swap_in = 1'b0;
            for (int j = 0; j < 10; j++) begin
                signed_mode = 1'($urandom_range(0, 1));
                a_in        = 8'($urandom_range(0, 255));
                a_valid_in  = ($urandom_range(0, 7) != 0);
                ps_sum_in   = 24'($urandom);
                ps_carry_in = 24'($urandom);
                wv = signed_mode ? 32'($signed(w)) : {24'd0, w};
                av = signed_mode ? 32'($signed(a_in)) : {24'd0, a_in};
                expected = 24'(32'(ps_sum_in) + 32'(ps_carry_in) + (a_valid_in ? wv * av : 32'd0));
                tick();
                checks++;
                if (resolved() !== expected) begin
                    errors++;
                    $display("[TB] FAIL random_mac w=%h: got %h, expected %h", w, resolved(), expected);
                end
`ifdef PE_WS_DBUF_RESOLVE_EN
                checks++;
                if (ps_carry_out !== 24'd0) begin
                    errors++;
                    $display("[TB] FAIL resolve_carry_zero: got %h, expected 0", ps_carry_out);
                end
`endif
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        signed_mode = 1'b1;
        idle_inputs();
        tick();
        tick();
        test_reset();
        test_chain_load();
        test_back_to_back();
        test_signed_unsigned();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
